inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
Fetch sequencer for the RV32I core. It owns the PC and drives the combinational instruction ROM read address. It buffers fetched words in a 2-entry queue and presents them to decode over a valid/ready handshake. It also handles branch/jump redirects, halt requests and address-fault detection.

Parameters:
P_RESET_PC, 32'h0000_0000, PC value loaded on reset.
P_IMEM_DEPTH, 64, instruction ROM depth in words. Legal byte addresses are 0 .. P_IMEM_DEPTH*4-4.

Ports:
iClk  input  1  system clock; all state updates on rising edge.
iRst  input  1  asynchronous, active-high reset.
oImemAddr  output  32  byte address to instruction ROM, always equal to current PC.
iImemData  input  32  ROM read data, combinational from oImemAddr in the same cycle.
oInstValid  output  1  head-of-queue instruction valid.
oInst  output  32  head-of-queue instruction word.
oInstPc  output  32  PC of the head-of-queue instruction.
iInstReady  input  1  decode accepts head this cycle.
iRedirect  input  1  branch/jump taken; single-cycle pulse.
iRedirectPc  input  32  redirect target byte address.
iHalt  input  1  level; while high, no new fetches are issued.
oFault  output  1  sticky fault flag (misaligned target or out-of-range PC).
oState  output  2  FSM state: 0 RUN, 1 HALT, 2 ERR.
oFetchCnt  output  32  count of words enqueued; wraps modulo 2^32.

Behaviour:
- Reset (async, iRst=1):
  - PC=P_RESET_PC, queue empty, state=RUN.
  - oInstValid=0, oInst=0, oInstPc=0, oFault=0, oFetchCnt=0.
  - oImemAddr=P_RESET_PC.
  - Reset asserted mid-operation discards the queue and any pending redirect immediately.
- Queue: 2 entries, each holding {inst, pc}.
  - oInstValid = (count != 0). oInst/oInstPc show the head.
  - Outputs are 0 when the queue is empty.
  - Pop when oInstValid & iInstReady.
- Enqueue condition: state==RUN & !iHalt & !iRedirect & PC in range & (count<2 | pop).
  - On enqueue: push {iImemData, PC}, PC<=PC+4, oFetchCnt++.
  - Push and pop in the same cycle keep the count unchanged.
  - Full with no pop: no push, PC held.
- Latency: the first edge after reset release enqueues P_RESET_PC; oInstValid goes high 1 cycle after reset deassertion.
- Redirect has the highest priority, above pop and push:
  - Flush the queue, so oInstValid=0 the next cycle.
  - No push this cycle.
  - If iRedirectPc[1:0]!=0 or iRedirectPc >= P_IMEM_DEPTH*4: state<=ERR, oFault<=1, PC<=iRedirectPc.
  - Otherwise PC<=iRedirectPc, oFault<=0, state<=RUN (or HALT if iHalt=1 the same cycle).
  - The redirected instruction is valid 1 cycle after the redirect cycle.
- FSM transitions:
  - RUN -> HALT when iHalt=1. The queue still drains via pops; no pushes occur.
  - HALT -> RUN when iHalt=0. Fetching resumes from the held PC on the same edge the state changes.
  - RUN -> ERR when PC >= P_IMEM_DEPTH*4 at an enqueue opportunity. No push occurs; oFault<=1 and PC is held. The queue still drains.
  - ERR is left only by reset or by a legal redirect. A legal redirect goes to RUN, or to HALT if iHalt=1.
- PC arithmetic is 32-bit and wraps at 2^32. The wrap address falls outside the ROM range and therefore triggers ERR.
- oImemAddr = PC at all times; the ROM indexes by addr[31:2].

Test Plan:
- Reset release, ROM[0..3]=A,B,C,D, iInstReady=1 -> oInstValid high from cycle 1; oInst/oInstPc = A/0, B/4, C/8, D/0xC on consecutive cycles; oFetchCnt=4.
- iInstReady=0 for 5 cycles after reset -> queue holds {0,4}, PC stays 8, oFetchCnt=2; on raising ready -> pops 0, 4, 8 back-to-back with no gap.
- iRedirect with iRedirectPc=0x20 while queue is full -> next cycle oInstValid=0; following cycle oInstPc=0x20, oInst=ROM[8]; stale entries 4 and 8 never appear.
- iRedirectPc=0x22 -> oFault=1, oState=ERR, no further valid after drain; then iRedirectPc=0x10 -> oFault=0, RUN, oInstPc=0x10.
- Free-run to PC=0x100 with P_IMEM_DEPTH=64 -> last valid oInstPc=0xFC, then oState=ERR, oFault=1, oImemAddr stays 0x100.
- iHalt=1 for 4 cycles with ready=1 -> queue drains, oState=HALT, PC frozen; iHalt=0 -> resumes at the frozen PC; iRedirect with iHalt=1 in the same cycle -> PC loaded, state HALT, no fetch.

Source files
------------

// File: rtl/inst_fetch_ctrl_if.sv
// inst_fetch_ctrl_if
//   Bundles the instruction-fetch sequencer's bus signals. These are the ROM
//   address and data, the decode handshake, redirect and halt control, and
//   the status outputs. The master modport is the fetch sequencer; the slave
//   modport is whatever sits on the other side (ROM + decode + bench).
//
//   Decode handshake: oInstValid/oInst/oInstPc describe the queue head.
//   A word transfers on every rising edge where oInstValid && iInstReady.
//   The payload stays stable while oInstValid is high and iInstReady is low,
//   unless a redirect or reset flushes the queue.
//
//   Signals:
//     oImemAddr   ROM byte address (= PC)
//     iImemData   ROM data, combinational from oImemAddr
//     oInstValid  head valid
//     oInst       head instruction
//     oInstPc     head PC
//     iInstReady  decode accepts the head
//     iRedirect   one-cycle taken branch/jump pulse
//     iRedirectPc redirect target
//     iHalt       level halt request
//     oFault      sticky fault flag
//     oState      FSM state (0 RUN, 1 HALT, 2 ERR)
//     oFetchCnt   count of enqueued words
interface inst_fetch_ctrl_if;
  logic [31:0] oImemAddr;
  logic [31:0] iImemData;
  logic        oInstValid;
  logic [31:0] oInst;
  logic [31:0] oInstPc;
  logic        iInstReady;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic        iHalt;
  logic        oFault;
  logic [1:0]  oState;
  logic [31:0] oFetchCnt;

  modport master (
    output oImemAddr, oInstValid, oInst, oInstPc, oFault, oState, oFetchCnt,
    input  iImemData, iInstReady, iRedirect, iRedirectPc, iHalt
  );

  modport slave (
    input  oImemAddr, oInstValid, oInst, oInstPc, oFault, oState, oFetchCnt,
    output iImemData, iInstReady, iRedirect, iRedirectPc, iHalt
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
//   Fetch sequencer. It owns the PC and reads the combinational instruction
//   ROM at the PC. Fetched words go into a 2-entry {inst, pc} queue that is
//   offered to decode over a valid/ready handshake. The block also handles
//   redirects, halt requests, and fault detection for misaligned or
//   out-of-range PCs.
//
//   Ports:
//     iClk  rising-edge clock
//     iRst  asynchronous active-high reset
//     bus   inst_fetch_ctrl_if.master (ROM, decode handshake, control, status)
module inst_fetch_ctrl #(
  parameter logic [31:0] P_RESET_PC   = 32'h0000_0000,
  parameter int          P_IMEM_DEPTH = 64
) (
  input  logic              iClk,
  input  logic              iRst,
  inst_fetch_ctrl_if.master bus
);

  localparam logic [31:0] LP_LIMIT = 32'(P_IMEM_DEPTH * 4);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  // e0 is the head, e1 the second entry. Empty entries are held at zero, so
  // the head outputs read 0 when the queue is empty.
  logic [31:0] e0_inst_q, e0_inst_d, e0_pc_q, e0_pc_d;
  logic [31:0] e1_inst_q, e1_inst_d, e1_pc_q, e1_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic pop, push, room, in_range, can_fetch, redir_bad;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    e0_inst_d   = e0_inst_q;
    e0_pc_d     = e0_pc_q;
    e1_inst_d   = e1_inst_q;
    e1_pc_d     = e1_pc_q;
    fault_d     = fault_q;
    fetch_cnt_d = fetch_cnt_q;

    pop       = (cnt_q != 2'd0) && bus.iInstReady;
    room      = (cnt_q != 2'd2) || pop;
    in_range  = pc_q < LP_LIMIT;
    // The HALT state with iHalt low also fetches. This lets fetch resume on
    // the same edge that the state returns to RUN.
    can_fetch = (state_q != ST_ERR) && !bus.iHalt;
    push      = can_fetch && !bus.iRedirect && in_range && room;
    redir_bad = (bus.iRedirectPc[1:0] != 2'b00) || (bus.iRedirectPc >= LP_LIMIT);

    if (bus.iRedirect) begin
      // A redirect overrides pop and push. It flushes the queue and reloads
      // the PC.
      cnt_d     = 2'd0;
      e0_inst_d = '0;
      e0_pc_d   = '0;
      e1_inst_d = '0;
      e1_pc_d   = '0;
      pc_d      = bus.iRedirectPc;
      if (redir_bad) begin
        state_d = ST_ERR;
        fault_d = 1'b1;
      end else begin
        fault_d = 1'b0;
        state_d = bus.iHalt ? ST_HALT : ST_RUN;
      end
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            e0_inst_d = bus.iImemData;
            e0_pc_d   = pc_q;
          end else begin
            e1_inst_d = bus.iImemData;
            e1_pc_d   = pc_q;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_inst_d = e1_inst_q;
          e0_pc_d   = e1_pc_q;
          e1_inst_d = '0;
          e1_pc_d   = '0;
          cnt_d     = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_inst_d = bus.iImemData;
            e0_pc_d   = pc_q;
          end else begin
            e0_inst_d = e1_inst_q;
            e0_pc_d   = e1_pc_q;
            e1_inst_d = bus.iImemData;
            e1_pc_d   = pc_q;
          end
        end
        default: ;
      endcase

      if (push) begin
        pc_d        = pc_q + 32'd4;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end

      if (state_q != ST_ERR) begin
        if (bus.iHalt) begin
          state_d = ST_HALT;
        end else if (!in_range && room) begin
          // The PC ran off the ROM end, or wrapped past 2^32. Hold the PC
          // and let the queue drain.
          state_d = ST_ERR;
          fault_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= ST_RUN;
      pc_q        <= P_RESET_PC;
      cnt_q       <= 2'd0;
      e0_inst_q   <= '0;
      e0_pc_q     <= '0;
      e1_inst_q   <= '0;
      e1_pc_q     <= '0;
      fault_q     <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      e0_inst_q   <= e0_inst_d;
      e0_pc_q     <= e0_pc_d;
      e1_inst_q   <= e1_inst_d;
      e1_pc_q     <= e1_pc_d;
      fault_q     <= fault_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign bus.oImemAddr  = pc_q;
  assign bus.oInstValid = (cnt_q != 2'd0);
  assign bus.oInst      = e0_inst_q;
  assign bus.oInstPc    = e0_pc_q;
  assign bus.oFault     = fault_q;
  assign bus.oState     = state_q;
  assign bus.oFetchCnt  = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] H = 2'd1;
  localparam logic [1:0] E = 2'd2;

  logic iClk;
  logic iRst;
  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(.P_RESET_PC(32'h0), .P_IMEM_DEPTH(64)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus.master)
  );

  // ---------------- clock / reset ----------------
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // ---------------- ROM model ----------------
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    return 32'h5A00_0000 + idx * 32'h0001_0001;
  endfunction

  assign bus.iImemData = (bus.oImemAddr < 32'd256) ?
                         rom_word({2'b00, bus.oImemAddr[31:2]}) : 32'hDEAD_BEEF;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [1:0] st, input logic f, input logic [31:0] addr);
    logic [31:0] exp_inst;
    exp_inst = v ? rom_word({2'b00, pc[31:2]}) : 32'h0;
    check({tag, ".valid"}, {31'b0, bus.oInstValid}, {31'b0, v});
    check({tag, ".inst_pc"}, bus.oInstPc, v ? pc : 32'h0);
    check({tag, ".inst"}, bus.oInst, exp_inst);
    check({tag, ".state"}, {30'b0, bus.oState}, {30'b0, st});
    check({tag, ".fault"}, {31'b0, bus.oFault}, {31'b0, f});
    check({tag, ".addr"}, bus.oImemAddr, addr);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        v;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        f;
    logic [31:0] addr;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  task automatic add(input logic rst, input logic rdy, input logic redir,
                     input logic [31:0] rpc, input logic halt, input logic v,
                     input logic [31:0] pc, input logic [1:0] st, input logic f,
                     input logic [31:0] addr, input logic [31:0] cnt);
    vecs[n_vec] = '{rst, rdy, redir, rpc, halt, v, pc, st, f, addr, cnt};
    n_vec++;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic rdy, input logic redir,
                       input logic [31:0] rpc, input logic halt);
    iRst            = rst;
    bus.iInstReady  = rdy;
    bus.iRedirect   = redir;
    bus.iRedirectPc = rpc;
    bus.iHalt       = halt;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Each row lists the inputs for one cycle and the outputs expected in
    // that cycle, before its rising edge.
    // Reset release and streaming with ready high.
    add(1,1,0,0,0, 0,0,R,0,32'h0,0);
    add(0,1,0,0,0, 0,0,R,0,32'h0,0);
    add(0,1,0,0,0, 1,32'h0,R,0,32'h4,1);
    add(0,1,0,0,0, 1,32'h4,R,0,32'h8,2);
    add(0,1,0,0,0, 1,32'h8,R,0,32'hC,3);
    add(0,1,0,0,0, 1,32'hC,R,0,32'h10,4);
    // Back-pressure: ready low for 5 cycles, then release.
    add(1,0,0,0,0, 0,0,R,0,32'h0,0);
    add(0,0,0,0,0, 0,0,R,0,32'h0,0);
    add(0,0,0,0,0, 1,32'h0,R,0,32'h4,1);
    add(0,0,0,0,0, 1,32'h0,R,0,32'h8,2);
    add(0,0,0,0,0, 1,32'h0,R,0,32'h8,2);
    add(0,0,0,0,0, 1,32'h0,R,0,32'h8,2);
    add(0,1,0,0,0, 1,32'h0,R,0,32'h8,2);
    add(0,1,0,0,0, 1,32'h4,R,0,32'hC,3);
    add(0,1,0,0,0, 1,32'h8,R,0,32'h10,4);
    // Redirect to 0x20 while full; stale entries are flushed.
    add(0,0,0,0,0, 1,32'hC,R,0,32'h14,5);
    add(0,0,1,32'h20,0, 1,32'hC,R,0,32'h14,5);
    add(0,0,0,0,0, 0,0,R,0,32'h20,5);
    add(0,1,0,0,0, 1,32'h20,R,0,32'h24,6);
    add(0,1,0,0,0, 1,32'h24,R,0,32'h28,7);
    // Misaligned redirect -> ERR, then a legal redirect recovers.
    add(0,1,1,32'h22,0, 1,32'h28,R,0,32'h2C,8);
    add(0,1,0,0,0, 0,0,E,1,32'h22,8);
    add(0,1,0,0,0, 0,0,E,1,32'h22,8);
    add(0,1,1,32'h10,0, 0,0,E,1,32'h22,8);
    add(0,1,0,0,0, 0,0,R,0,32'h10,8);
    add(0,1,0,0,0, 1,32'h10,R,0,32'h14,9);
    // Run off the ROM end.
    add(0,1,1,32'hF0,0, 1,32'h14,R,0,32'h18,10);
    add(0,1,0,0,0, 0,0,R,0,32'hF0,10);
    add(0,1,0,0,0, 1,32'hF0,R,0,32'hF4,11);
    add(0,1,0,0,0, 1,32'hF4,R,0,32'hF8,12);
    add(0,1,0,0,0, 1,32'hF8,R,0,32'hFC,13);
    add(0,1,0,0,0, 1,32'hFC,R,0,32'h100,14);
    add(0,1,0,0,0, 0,0,E,1,32'h100,14);
    add(0,1,0,0,0, 0,0,E,1,32'h100,14);
    // Halt for 4 cycles, resume, then redirect with halt.
    add(1,1,0,0,0, 0,0,R,0,32'h0,0);
    add(0,1,0,0,0, 0,0,R,0,32'h0,0);
    add(0,1,0,0,0, 1,32'h0,R,0,32'h4,1);
    add(0,1,0,0,1, 1,32'h4,R,0,32'h8,2);
    add(0,1,0,0,1, 0,0,H,0,32'h8,2);
    add(0,1,0,0,1, 0,0,H,0,32'h8,2);
    add(0,1,0,0,1, 0,0,H,0,32'h8,2);
    add(0,1,0,0,0, 0,0,H,0,32'h8,2);
    add(0,1,0,0,0, 1,32'h8,R,0,32'hC,3);
    add(0,1,1,32'h40,1, 1,32'hC,R,0,32'h10,4);
    add(0,1,0,0,1, 0,0,H,0,32'h40,4);
    add(0,1,0,0,1, 0,0,H,0,32'h40,4);
    add(0,1,0,0,0, 0,0,H,0,32'h40,4);
    add(0,1,0,0,0, 1,32'h40,R,0,32'h44,5);

    for (int i = 0; i < n_vec; i++) begin
      @(negedge iClk);
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].rpc, vecs[i].halt);
      #1;
      expect_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].st,
                 vecs[i].f, vecs[i].addr);
      check($sformatf("vec%0d.cnt", i), bus.oFetchCnt, vecs[i].cnt);
    end

    // ---- hand sequence: ERR reached with a full queue, which still drains ----
    @(negedge iClk);
    drive(1'b0, 1'b0, 1'b1, 32'hF8, 1'b0);
    @(negedge iClk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge iClk);
    @(negedge iClk);
    #1 expect_out("err_full0", 1'b1, 32'hF8, R, 1'b0, 32'h100);
    @(negedge iClk);
    #1 expect_out("err_full1", 1'b1, 32'hF8, R, 1'b0, 32'h100);
    bus.iInstReady = 1'b1;
    @(negedge iClk);
    #1 expect_out("err_drain0", 1'b1, 32'hFC, E, 1'b1, 32'h100);
    @(negedge iClk);
    #1 expect_out("err_drain1", 1'b0, 32'h0, E, 1'b1, 32'h100);
    // Out-of-range redirect from ERR stays in ERR.
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    @(negedge iClk);
    #1 expect_out("err_far", 1'b0, 32'h0, E, 1'b1, 32'hFFFF_FFFC);
    // Legal redirect with halt high goes from ERR to HALT.
    drive(1'b0, 1'b1, 1'b1, 32'h8, 1'b1);
    @(negedge iClk);
    #1 expect_out("err_to_halt", 1'b0, 32'h0, H, 1'b0, 32'h8);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge iClk);
    #1 expect_out("halt_resume", 1'b1, 32'h8, R, 1'b0, 32'hC);

    // ---- hand sequence: async reset mid-cycle drops queue and pending redirect ----
    drive(1'b0, 1'b1, 1'b1, 32'h30, 1'b0);
    #1 iRst = 1'b1;
    #1 expect_out("async_rst", 1'b0, 32'h0, R, 1'b0, 32'h0);
    check("async_rst.cnt", bus.oFetchCnt, 32'h0);
    @(negedge iClk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1 expect_out("rst_release", 1'b0, 32'h0, R, 1'b0, 32'h0);
    @(negedge iClk);
    #1 expect_out("rst_first", 1'b1, 32'h0, R, 1'b0, 32'h4);
    check("rst_first.cnt", bus.oFetchCnt, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
